// File: rtl/pwm_pkg.sv
// Shared PWM link definitions: duty encoding, FSM states and divider latency.
package pwm_pkg;

  // Duty is reported in 10% steps, 0..DUTY_STEPS
  localparam int unsigned DUTY_STEPS = 10;
  localparam int unsigned DUTY_W     = 4;

  // Cycles from the capturing rise pulse to the valid_o pulse
  localparam int unsigned DIV_LAT    = 5;

  // Number of quotient bits produced by the restoring divider
  localparam int unsigned DIV_ITERS  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_duty_capture_sync.sv
// Input synchroniser followed by a one-flop edge detector.
module pwm_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // Shift the asynchronous input through the synchroniser chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
    end
  end

  // Remember the previous synchronised level for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 1'b0;
    end else begin
      prev <= sync[SYNC_STAGES-1];
    end
  end

  // Rise and fall are mutually exclusive single-cycle pulses
  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/pwm_duty_capture.sv
// PWM receiver: measures period, high time and rounded duty (0..10) of pwm_in.
module pwm_duty_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period_o,
  output logic [CNT_W-1:0]  high_o,
  output logic [DUTY_W-1:0] duty_o,
  output logic              valid_o,
  output logic              timeout_o,
  output logic              overrun_o
);

  localparam int unsigned DIV_W = CNT_W + 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [2:0] STEP_LOAD = 3'(DIV_LAT);
  localparam logic [2:0] STEP_LAST = 3'd2;

  logic level, rise, fall;

  pwm_state_e state, state_nxt;

  logic start, fall_go, cap_go, cap_drop, tmo_fire;
  logic div_busy, tmo_hit, bit_c;

  logic [CNT_W-1:0]  cnt, hi_lat, tmo_cnt;
  logic [CNT_W-1:0]  cap_per, cap_hi;
  logic [DIV_W-1:0]  rem, dsh;
  logic [DUTY_W-1:0] quo, q_fin;
  logic [2:0]        div_step;

  pwm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (pwm_in),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  // Divider is busy from the load until the cycle its result is visible
  assign div_busy = (div_step != 3'd0);
  assign tmo_hit  = (tmo_cnt == CNT_W'(TIMEOUT));
  assign bit_c    = (rem >= dsh);
  assign q_fin    = {quo[DUTY_W-2:0], bit_c};

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control strobes
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    fall_go   = 1'b0;
    cap_go    = 1'b0;
    cap_drop  = 1'b0;
    tmo_fire  = 1'b0;
    if (!ena) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_nxt = HIGH;
            start     = 1'b1;
          end
        end
        HIGH: begin
          if (fall) begin
            state_nxt = LOW;
            fall_go   = 1'b1;
          end else if (tmo_hit) begin
            state_nxt = IDLE;
            tmo_fire  = 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            state_nxt = HIGH;
            start     = 1'b1;
            if (div_busy) begin
              cap_drop = 1'b1;
            end else begin
              cap_go   = 1'b1;
            end
          end else if (tmo_hit) begin
            state_nxt = IDLE;
            tmo_fire  = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Period counter, high-time latch and edge-age counter (saturating)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      hi_lat  <= '0;
      tmo_cnt <= '0;
    end else if (start) begin
      cnt     <= CNT_W'(1);
      tmo_cnt <= CNT_W'(1);
    end else if (state != IDLE && state_nxt != IDLE) begin
      cnt <= (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
      if (fall_go) begin
        hi_lat  <= cnt;
        tmo_cnt <= CNT_W'(1);
      end else begin
        tmo_cnt <= (tmo_cnt == CNT_MAX) ? tmo_cnt : tmo_cnt + CNT_W'(1);
      end
    end
  end

  // Restoring divider: q = floor((10*high + period/2) / period), MSB first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_per  <= '0;
      cap_hi   <= '0;
      rem      <= '0;
      dsh      <= '0;
      quo      <= '0;
      div_step <= 3'd0;
    end else if (!ena || tmo_fire) begin
      div_step <= 3'd0;
    end else if (cap_go) begin
      cap_per  <= cnt;
      cap_hi   <= hi_lat;
      rem      <= DIV_W'(hi_lat) * DIV_W'(DUTY_STEPS) + DIV_W'(cnt >> 1);
      dsh      <= DIV_W'(cnt) << (DIV_ITERS - 1);
      quo      <= '0;
      div_step <= STEP_LOAD;
    end else if (div_busy) begin
      div_step <= div_step - 3'd1;
      if (div_step >= STEP_LAST) begin
        if (bit_c) begin
          rem <= rem - dsh;
        end
        quo <= q_fin;
        dsh <= dsh >> 1;
      end
    end
  end

  // Result registers, valid pulse and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_o  <= '0;
      high_o    <= '0;
      duty_o    <= '0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (ena && rise) begin
        timeout_o <= 1'b0;
      end
      if (cap_drop) begin
        overrun_o <= 1'b1;
      end
      if (tmo_fire) begin
        period_o  <= '0;
        high_o    <= '0;
        duty_o    <= level ? DUTY_W'(DUTY_STEPS) : '0;
        valid_o   <= 1'b1;
        timeout_o <= 1'b1;
      end else if (ena && div_step == STEP_LAST) begin
        period_o <= cap_per;
        high_o   <= cap_hi;
        duty_o   <= q_fin;
        valid_o  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Self-checking bench for pwm_duty_capture with an edge-level reference model.
module tb_pwm_duty_capture;
  import pwm_pkg::*;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned TMO   = 100;
  localparam int LAT     = int'(SYNC + DIV_LAT);
  localparam int TMO_OBS = int'(SYNC + TMO + 1);
  localparam int MIN_GAP = 6;

  logic clk = 1'b0;
  logic rst, ena, pwm_in;
  logic [CNT_W-1:0] period_o, high_o;
  logic [3:0] duty_o;
  logic valid_o, timeout_o, overrun_o;

  pwm_duty_capture #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ena(ena), .pwm_in(pwm_in),
    .period_o(period_o), .high_o(high_o), .duty_o(duty_o),
    .valid_o(valid_o), .timeout_o(timeout_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int per; int hi; int duty; bit tmo; } ev_t;
  ev_t expq[$];

  int now = 0;
  int n_checks = 0;
  int n_pass = 0;
  bit m_active = 1'b0;
  int last_rise = 0, last_fall = 0, last_edge = 0, last_acc = -1000;
  bit exp_tmo = 1'b0, exp_ovr = 1'b0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d (tick %0d)", tag, obs, exp, now);
  endtask

  // Round-half-up of 10*h/p
  function automatic int ref_duty(int h, int p);
    return (20 * h + p) / (2 * p);
  endfunction

  // Advance one cycle, predict timeouts and compare any due result
  task automatic tick();
    ev_t e;
    @(negedge clk);
    now++;
    if (m_active && ena && (now - last_edge) == TMO_OBS) begin
      expq.push_back('{now, 0, 0, (pwm_in ? int'(DUTY_STEPS) : 0), 1'b1});
      m_active = 1'b0;
      exp_tmo  = 1'b1;
    end
    if (expq.size() != 0 && expq[0].due == now) begin
      e = expq.pop_front();
      check("valid",   32'(valid_o),   32'(1));
      check("period",  32'(period_o),  32'(e.per));
      check("high",    32'(high_o),    32'(e.hi));
      check("duty",    32'(duty_o),    32'(e.duty));
      check("tmo_flag", 32'(timeout_o), 32'(e.tmo));
    end else if (valid_o !== 1'b0) begin
      check("spurious_valid", 32'(valid_o), 32'(0));
    end
  endtask

  // Drive pwm_in and update the edge-level model
  task automatic set_pwm(bit v);
    if (v && !pwm_in && ena) begin
      exp_tmo = 1'b0;
      if (m_active) begin
        if (now - last_acc >= MIN_GAP) begin
          expq.push_back('{now + LAT, now - last_rise, last_fall - last_rise,
                           ref_duty(last_fall - last_rise, now - last_rise), 1'b0});
          last_acc = now;
        end else begin
          exp_ovr = 1'b1;
        end
      end
      m_active  = 1'b1;
      last_rise = now;
      last_edge = now;
    end else if (!v && pwm_in && m_active) begin
      last_fall = now;
      last_edge = now;
    end
    pwm_in = v;
  endtask

  task automatic wave(int h, int p, int n);
    for (int i = 0; i < n; i++) begin
      set_pwm(1'b1);
      repeat (h) tick();
      set_pwm(1'b0);
      repeat (p - h) tick();
    end
  endtask

  task automatic hold(bit v, int n);
    set_pwm(v);
    repeat (n) tick();
  endtask

  task automatic model_reset();
    expq.delete();
    m_active = 1'b0;
    exp_tmo  = 1'b0;
    exp_ovr  = 1'b0;
    last_acc = -1000;
  endtask

  task automatic check_zero(string tag);
    check({tag, "_period"}, 32'(period_o), 32'(0));
    check({tag, "_high"},   32'(high_o),   32'(0));
    check({tag, "_duty"},   32'(duty_o),   32'(0));
    check({tag, "_valid"},  32'(valid_o),  32'(0));
    check({tag, "_tmo"},    32'(timeout_o), 32'(0));
    check({tag, "_ovr"},    32'(overrun_o), 32'(0));
  endtask

  initial begin
    int p, h;
    rst = 1'b1; ena = 1'b1; pwm_in = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Loop-back at 50%, then 90%, then constant high
    wave(5, 10, 6);
    check("ovr_clear", 32'(overrun_o), 32'(exp_ovr));
    wave(9, 10, 4);
    hold(1'b1, TMO + 20);
    check("tmo_high_flag", 32'(timeout_o), 32'(exp_tmo));
    check("tmo_high_duty", 32'(duty_o), 32'(DUTY_STEPS));

    // Line stuck low after running, then recovery
    wave(3, 10, 3);
    hold(1'b0, TMO + 20);
    check("tmo_low_flag", 32'(timeout_o), 32'(exp_tmo));
    wave(3, 10, 3);
    check("tmo_cleared", 32'(timeout_o), 32'(exp_tmo));

    // Period 4 overruns the divider
    wave(2, 4, 8);
    check("ovr_set", 32'(overrun_o), 32'(exp_ovr));
    wave(3, 10, 3);
    check("ovr_sticky", 32'(overrun_o), 32'(exp_ovr));

    // Rounding corners
    wave(3, 7, 4);
    wave(1, 20, 3);

    // Random waveforms
    for (int r = 0; r < 10; r++) begin
      p = int'($urandom_range(40, 6));
      h = int'($urandom_range(p - 1, 1));
      wave(h, p, int'($urandom_range(4, 2)));
    end

    // Reset shortly after a capturing rise
    wave(5, 10, 3);
    set_pwm(1'b1);
    repeat (4) tick();
    rst = 1'b1;
    pwm_in = 1'b0;
    model_reset();
    tick();
    check_zero("midrst");
    repeat (2) tick();
    rst = 1'b0;
    wave(5, 10, 4);

    // Enable dropped for three cycles mid-period
    set_pwm(1'b1);
    repeat (3) tick();
    ena = 1'b0;
    m_active = 1'b0;
    expq = expq.find(x) with (x.due <= now);
    repeat (2) tick();
    set_pwm(1'b0);
    tick();
    ena = 1'b1;
    repeat (4) tick();
    wave(5, 10, 4);

    repeat (20) tick();
    check("pending_events", 32'(expq.size()), 32'(0));
    check("ovr_final", 32'(overrun_o), 32'(exp_ovr));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
